// File: rtl/riscv_div_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
package riscv_div_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned CNT_W_DEF = 6;
   localparam logic [XLEN_DEF-1:0] DIV_BY_ZERO_Q = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   typedef enum logic [2:0] {
      OP_DIV  = 3'b100,
      OP_DIVU = 3'b101,
      OP_REM  = 3'b110,
      OP_REMU = 3'b111
   } div_op_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Execute-stage handshake between the core pipeline and the divide sequencer.
interface div_sequencer_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            valid;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, src_a, src_b, flush,
      input  stall, busy, valid, result
   );

   modport slave (
      input  start, funct3, src_a, src_b, flush,
      output stall, busy, valid, result
   );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);

   logic [XLEN:0] partial;
   logic          ge;

   // partial needs XLEN+1 bits: the shifted-in bit can push it past XLEN
   always_comb begin
      partial = {rem_in, quo_in[XLEN-1]};
      ge      = (partial >= {1'b0, divisor});
      rem_out = ge ? XLEN'(partial - {1'b0, divisor}) : partial[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], ge};
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer that stalls F/D/E until the result is ready.
// Optional DIV_EARLY_OUT_EN: a zero divisor skips the iterations and finishes in one cycle.
module div_sequencer
   import riscv_div_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
   input  logic          clk,
   input  logic          rst,
   div_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

   div_state_e      state, state_nxt;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0] rem_q, quo_q, div_q;
   logic            sign_a_q, sign_b_q, is_rem_q;
`ifndef DIV_EARLY_OUT_EN
   logic            b_zero_q;
`endif

   logic            accept, last_step;
   logic            in_signed, in_rem, b_is_zero;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN-1:0] rem_nxt, quo_nxt;
   logic [XLEN-1:0] q_fix, r_fix, final_res;

   // operand decode at acceptance
   always_comb begin
      in_signed = (div_op_e'(bus.funct3) == OP_DIV) || (div_op_e'(bus.funct3) == OP_REM);
      in_rem    = (div_op_e'(bus.funct3) == OP_REM) || (div_op_e'(bus.funct3) == OP_REMU);
      b_is_zero = (bus.src_b == '0);
      a_mag     = (in_signed && bus.src_a[XLEN-1]) ? -bus.src_a : bus.src_a;
      b_mag     = (in_signed && bus.src_b[XLEN-1]) ? -bus.src_b : bus.src_b;
   end

   div_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (div_q),
      .rem_out (rem_nxt),
      .quo_out (quo_nxt)
   );

   // sign fix-up on the final step's magnitudes; -2^31/-1 wraps back to 0x8000_0000
   always_comb begin
      q_fix = (sign_a_q ^ sign_b_q) ? -quo_nxt : quo_nxt;
      r_fix = sign_a_q ? -rem_nxt : rem_nxt;
`ifndef DIV_EARLY_OUT_EN
      if (b_zero_q) q_fix = XLEN'(DIV_BY_ZERO_Q);
`endif
      final_res = is_rem_q ? r_fix : q_fix;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start && !bus.flush) begin
`ifdef DIV_EARLY_OUT_EN
               state_nxt = b_is_zero ? DONE : CALC;
`else
               state_nxt = CALC;
`endif
            end
         end
         CALC: begin
            if (bus.flush)             state_nxt = IDLE;
            else if (count == LAST_CNT) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // stall is combinational so the pipeline freezes in the accepting cycle
   always_comb begin
      accept    = (state == IDLE) && bus.start && !bus.flush;
      last_step = (state == CALC) && (count == LAST_CNT) && !bus.flush;
      bus.stall = rst && (accept || ((state == CALC) && !bus.flush));
      bus.busy  = (state != IDLE);
      bus.valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         div_q      <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         is_rem_q   <= 1'b0;
`ifndef DIV_EARLY_OUT_EN
         b_zero_q   <= 1'b0;
`endif
         bus.result <= '0;
      end else if (accept) begin
         count    <= '0;
         rem_q    <= '0;
         quo_q    <= a_mag;
         div_q    <= b_mag;
         sign_a_q <= in_signed && bus.src_a[XLEN-1];
         sign_b_q <= in_signed && bus.src_b[XLEN-1];
         is_rem_q <= in_rem;
`ifdef DIV_EARLY_OUT_EN
         if (b_is_zero) bus.result <= in_rem ? bus.src_a : XLEN'(DIV_BY_ZERO_Q);
`else
         b_zero_q <= b_is_zero;
`endif
      end else if (state == CALC) begin
         rem_q <= rem_nxt;
         quo_q <= quo_nxt;
         count <= count + CNT_W'(1);
         if (last_step) bus.result <= final_res;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed spec vectors, flush, reset and random divides.
module tb_div_sequencer;

`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   div_sequencer_if #(.XLEN(32)) bus ();
   div_sequencer #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
   } vec_t;

   function automatic int exp_lat(logic [31:0] b);
      return (EARLY_EN && b == 32'd0) ? 1 : 33;
   endfunction

   // RV32M semantics from plain arithmetic
   function automatic logic [31:0] ref_div(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic drive_idle();
      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      bus.funct3 = 3'b000;
      bus.src_a  = '0;
      bus.src_b  = '0;
   endtask

   // issue one divide, hold start until valid, report latency/result/stall profile
   task automatic do_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res,
                         output int stall_hi, output logic stall_at_valid);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.funct3 = op; bus.src_a = a; bus.src_b = b; bus.flush = 1'b0;
      lat = -1; res = 'x; stall_hi = 0; stall_at_valid = 1'b1;
      @(negedge clk);
      if (bus.stall) stall_hi++;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (bus.valid) begin
            lat = k; res = bus.result; stall_at_valid = bus.stall;
            break;
         end
         if (bus.stall) stall_hi++;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b0;
      bus.start = 1'b1; bus.funct3 = 3'b101; bus.src_b = 32'd3;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
      checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", bus.valid); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b exp 0", bus.stall); end
      checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h exp 0", bus.result); end
      @(posedge clk); #1;
      drive_idle();
      rst = 1'b1;
   endtask

   task automatic test_directed();
      vec_t v[$];
      int lat, sh;
      logic [31:0] res;
      logic sv;
      v.push_back('{3'b101, 32'd100,        32'd7,        32'd14});
      v.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF});
      v.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD});
      v.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
      v.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
      v.push_back('{3'b100, 32'd5,          32'd0,        32'hFFFF_FFFF});
      v.push_back('{3'b110, 32'd5,          32'd0,        32'd5});
      v.push_back('{3'b111, 32'd100,        32'd7,        32'd2});
      v.push_back('{3'b100, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF});
      v.push_back('{3'b110, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9});
      v.push_back('{3'b101, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF});
      foreach (v[i]) begin
         do_div(v[i].op, v[i].a, v[i].b, lat, res, sh, sv);
         checks++;
         if (res !== v[i].e) begin
            failures++;
            $display("FAIL directed_result[%0d] op=%b a=%h b=%h: got %h exp %h", i, v[i].op, v[i].a, v[i].b, res, v[i].e);
         end
         checks++;
         if (lat != exp_lat(v[i].b)) begin
            failures++; $display("FAIL directed_latency[%0d]: got %0d exp %0d", i, lat, exp_lat(v[i].b));
         end
         checks++;
         if (sh != exp_lat(v[i].b)) begin
            failures++; $display("FAIL directed_stall_cycles[%0d]: got %0d exp %0d", i, sh, exp_lat(v[i].b));
         end
         checks++;
         if (sv !== 1'b0) begin failures++; $display("FAIL directed_stall_at_valid[%0d]: got %b exp 0", i, sv); end
      end
   endtask

   task automatic test_flush();
      int vcount = 0;
      int lat, sh;
      logic [31:0] res;
      logic sv, stall_flush;
      stall_flush = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.funct3 = 3'b101; bus.src_a = 32'd1000; bus.src_b = 32'd3;
      @(negedge clk);
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         if (k == 10) begin bus.flush = 1'b1; bus.start = 1'b0; end
         if (k == 11) bus.flush = 1'b0;
         @(negedge clk);
         if (bus.valid) vcount++;
         if (k == 10) stall_flush = bus.stall;
      end
      checks++; if (vcount != 0) begin failures++; $display("FAIL flush_no_valid: got %0d pulses exp 0", vcount); end
      checks++; if (stall_flush !== 1'b0) begin failures++; $display("FAIL flush_stall_drop: got %b exp 0", stall_flush); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_idle_busy: got %b exp 0", bus.busy); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL flush_idle_stall: got %b exp 0", bus.stall); end
      do_div(3'b100, 32'hFFFF_FF9C, 32'd7, lat, res, sh, sv);
      checks++;
      if (res !== ref_div(3'b100, 32'hFFFF_FF9C, 32'd7)) begin
         failures++; $display("FAIL flush_restart_result: got %h exp %h", res, ref_div(3'b100, 32'hFFFF_FF9C, 32'd7));
      end
      checks++; if (lat != 33) begin failures++; $display("FAIL flush_restart_latency: got %0d exp 33", lat); end
   endtask

   task automatic test_hold_start();
      int vcount = 0;
      logic busy34;
      busy34 = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.funct3 = 3'b111; bus.src_a = 32'd12345; bus.src_b = 32'd100;
      @(negedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (k == 34) bus.start = 1'b0;
         @(negedge clk);
         if (bus.valid) vcount++;
         if (k == 34) busy34 = bus.busy;
      end
      checks++; if (vcount != 1) begin failures++; $display("FAIL hold_one_pulse: got %0d pulses exp 1", vcount); end
      checks++; if (busy34 !== 1'b0) begin failures++; $display("FAIL hold_idle_after_done: got busy=%b exp 0", busy34); end
   endtask

   task automatic test_back_to_back();
      int vk[$];
      logic [31:0] vr[$];
      @(posedge clk); #1;
      bus.start = 1'b1; bus.funct3 = 3'b101; bus.src_a = 32'd100; bus.src_b = 32'd7;
      @(negedge clk);
      for (int k = 1; k <= 75; k++) begin
         @(posedge clk); #1;
         if (k == 34) begin bus.funct3 = 3'b110; bus.src_a = 32'hFFFF_FF00; bus.src_b = 32'd7; end
         if (k == 68) bus.start = 1'b0;
         @(negedge clk);
         if (bus.valid) begin vk.push_back(k); vr.push_back(bus.result); end
      end
      checks++;
      if (vk.size() != 2) begin
         failures++; $display("FAIL b2b_pulse_count: got %0d exp 2", vk.size());
      end else begin
         checks++; if (vk[0] != 33) begin failures++; $display("FAIL b2b_first_latency: got %0d exp 33", vk[0]); end
         checks++; if (vk[1] != 67) begin failures++; $display("FAIL b2b_second_latency: got %0d exp 67", vk[1]); end
         checks++; if (vr[0] !== 32'd14) begin failures++; $display("FAIL b2b_first_result: got %h exp %h", vr[0], 32'd14); end
         checks++;
         if (vr[1] !== ref_div(3'b110, 32'hFFFF_FF00, 32'd7)) begin
            failures++; $display("FAIL b2b_second_result: got %h exp %h", vr[1], ref_div(3'b110, 32'hFFFF_FF00, 32'd7));
         end
      end
   endtask

   task automatic test_reset_midop();
      int lat, sh;
      logic [31:0] res;
      logic sv;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.funct3 = 3'b100; bus.src_a = 32'd999; bus.src_b = 32'd4;
      @(negedge clk);
      for (int k = 1; k < 20; k++) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b exp 0", bus.busy); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL midrst_stall: got %b exp 0", bus.stall); end
      checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b exp 0", bus.valid); end
      checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL midrst_result: got %h exp 0", bus.result); end
      @(negedge clk);
      drive_idle();
      rst = 1'b1;
      do_div(3'b100, 32'd999, 32'hFFFF_FFFC, lat, res, sh, sv);
      checks++;
      if (res !== ref_div(3'b100, 32'd999, 32'hFFFF_FFFC)) begin
         failures++; $display("FAIL midrst_fresh_result: got %h exp %h", res, ref_div(3'b100, 32'd999, 32'hFFFF_FFFC));
      end
      checks++; if (lat != 33) begin failures++; $display("FAIL midrst_fresh_latency: got %0d exp 33", lat); end
   endtask

   task automatic test_random();
      int lat, sh;
      logic [31:0] res, a, b, e;
      logic [2:0] op;
      logic sv;
      for (int i = 0; i < 30; i++) begin
         op = 3'(3'b100 + 3'($urandom_range(0, 3)));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
            2: b = 32'($urandom_range(1, 15));
            3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: b = $urandom;
         endcase
         e = ref_div(op, a, b);
         do_div(op, a, b, lat, res, sh, sv);
         checks++;
         if (res !== e) begin
            failures++; $display("FAIL random_result[%0d] op=%b a=%h b=%h: got %h exp %h", i, op, a, b, res, e);
         end
         checks++;
         if (lat != exp_lat(b)) begin
            failures++; $display("FAIL random_latency[%0d]: got %0d exp %0d", i, lat, exp_lat(b));
         end
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_directed();
      test_flush();
      test_hold_start();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
